// File: rtl/router_fifo_pkt.sv
// Packet-aware output FIFO for one router destination port: stores header-tagged
// bytes, tracks the packet being drained and flags framing errors on the read side.
module router_fifo_pkt #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              pkt_busy,
  output logic              err_orphan,
  output logic              err_trunc
);

  localparam logic [ADDR_W:0]   AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [DATA_W-2:0] CNT_ONE = (DATA_W-1)'(1);

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   occ;
  logic [DATA_W-2:0] rd_cnt;
  logic [DATA_W:0]   rd_entry;
  logic              wr_acc;
  logic              rd_acc;
  logic              flush;

  // Bytes left in a packet after its header: payload plus the trailing parity byte.
  function automatic logic [DATA_W-2:0] pkt_remaining(input logic [DATA_W-3:0] len);
    pkt_remaining = {1'b0, len} + CNT_ONE;
  endfunction

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full = (occ >= AF_CNT);
  assign count       = occ;

  assign flush    = !resetn || soft_reset;
  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  // Storage is never cleared; a flush only discards the pending write.
  always_ff @(posedge clock) begin
    if (!flush && wr_acc)
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  // Pointer, occupancy and read-data stage
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry[DATA_W-1:0];
      end
      data_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Packet framing tracker, advanced by each accepted read
  always_ff @(posedge clock) begin
    if (flush) begin
      rd_cnt     <= '0;
      pkt_busy   <= 1'b0;
      err_orphan <= 1'b0;
      err_trunc  <= 1'b0;
    end else if (rd_acc) begin
      if (rd_entry[DATA_W]) begin
        rd_cnt   <= pkt_remaining(rd_entry[DATA_W-1:2]);
        pkt_busy <= 1'b1;
        if (pkt_busy)
          err_trunc <= 1'b1;
      end else if (pkt_busy) begin
        rd_cnt <= rd_cnt - 1'b1;
        if (rd_cnt == CNT_ONE)
          pkt_busy <= 1'b0;
      end else begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Scoreboard bench for router_fifo_pkt: directed traffic, a FIFO model queues the
// expected read bytes and a negedge monitor checks every data_valid pulse.
module tb_router_fifo_pkt;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 14;

  logic              clock = 1'b0;
  logic              resetn;
  logic              soft_reset;
  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              pkt_busy;
  logic              err_orphan;
  logic              err_trunc;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;
  int p0;

  logic [DATA_W:0]   mdl[$];
  logic [DATA_W-1:0] exp_q[$];

  router_fifo_pkt #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .pkt_busy(pkt_busy), .err_orphan(err_orphan), .err_trunc(err_trunc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every byte the DUT presents must be the next one the model predicted.
  always @(negedge clock) begin
    if (data_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got data_out %0h with no byte expected", data_out);
      end else begin
        chk("rd_data", data_out, exp_q.pop_front());
      end
    end
  end

  // One clock with the given request; the model decides acceptance from pre-edge occupancy.
  task automatic cyc(input bit we, input bit lfd, input logic [7:0] d, input bit re);
    bit wacc, racc;
    logic [DATA_W:0] e;
    write_enb = we;
    lfd_state = lfd;
    data_in   = d;
    read_enb  = re;
    wacc = we && (mdl.size() < DEPTH);
    racc = re && (mdl.size() > 0);
    if (racc) begin
      e = mdl.pop_front();
      exp_q.push_back(e[DATA_W-1:0]);
    end
    if (wacc) mdl.push_back({lfd, d});
    @(posedge clock); #1;
    write_enb = 1'b0;
    lfd_state = 1'b0;
    read_enb  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic flush_cycle(input bit we);
    soft_reset = 1'b1;
    write_enb  = we;
    lfd_state  = 1'b0;
    data_in    = 8'h77;
    @(posedge clock); #1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    mdl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = '0; read_enb = 1'b0;

    // 1: reset then soft reset
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", pkt_busy, 0);
    chk("rst_errs", {err_orphan, err_trunc}, 0);
    flush_cycle(0);
    chk("srst_empty", empty, 1);
    chk("srst_count", count, 0);

    // 2: one complete packet, header 8'h11 = len 4, addr 1
    cyc(1, 1, 8'h11, 0);
    cyc(1, 0, 8'h3C, 0);
    cyc(1, 0, 8'hA5, 0);
    cyc(1, 0, 8'h0F, 0);
    cyc(1, 0, 8'hE1, 0);
    cyc(1, 0, 8'h66, 0);
    idle(2);
    chk("pkt_count", count, 6);
    p0 = pulses;
    cyc(0, 0, 8'h00, 1);
    chk("pkt_busy_hdr", pkt_busy, 1);
    chk("pkt_rdcnt_hdr", dut.rd_cnt, 5);
    repeat (4) cyc(0, 0, 8'h00, 1);
    chk("pkt_busy_pay", pkt_busy, 1);
    cyc(0, 0, 8'h00, 1);
    chk("pkt_busy_par", pkt_busy, 0);
    chk("pkt_empty", empty, 1);
    idle(1);
    chk("pkt_pulses", pulses - p0, 6);
    chk("pkt_errs", {err_orphan, err_trunc}, 0);

    // 3: fill, almost_full/full thresholds, overflow, read+write while full
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'h20 + 8'(i), 0);
      if (i == 12) chk("af_at13", almost_full, 0);
      if (i == 13) chk("af_at14", almost_full, 1);
      if (i == 14) chk("full_at15", full, 0);
    end
    chk("full_at16", full, 1);
    chk("count_16", count, 16);
    cyc(1, 0, 8'hEE, 0);
    chk("overflow_count", count, 16);
    cyc(1, 0, 8'hDD, 1);
    chk("rw_full_count", count, 15);
    chk("rw_full_flag", full, 0);
    chk("rw_full_af", almost_full, 1);
    repeat (15) cyc(0, 0, 8'h00, 1);
    chk("drain_empty", empty, 1);
    chk("drain_af", almost_full, 0);

    // 4: pointer wrap
    flush_cycle(0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'h40 + 8'(i), 0);
    repeat (10) cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h60 + 8'(i), 0);
    chk("wrap_full", full, 1);
    chk("wrap_count", count, 16);
    repeat (16) cyc(0, 0, 8'h00, 1);
    chk("wrap_empty", empty, 1);
    chk("wrap_count0", count, 0);

    // 5: flush mid-packet with a concurrent write
    flush_cycle(0);
    cyc(1, 1, 8'h12, 0);
    cyc(1, 0, 8'hA1, 0);
    cyc(1, 0, 8'hA2, 0);
    cyc(1, 0, 8'hA3, 0);
    cyc(1, 0, 8'hA4, 0);
    cyc(1, 0, 8'h5A, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    chk("mid_busy", pkt_busy, 1);
    chk("mid_count", count, 4);
    flush_cycle(1);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_busy", pkt_busy, 0);
    chk("fl_valid", data_valid, 0);
    chk("fl_data", data_out, 0);
    cyc(0, 0, 8'h00, 1);
    chk("fl_write_absent", data_valid, 0);
    chk("fl_count_after", count, 0);

    // 6: orphan byte, then truncated packet
    cyc(1, 0, 8'hAA, 0);
    cyc(0, 0, 8'h00, 1);
    chk("orphan_flag", err_orphan, 1);
    chk("orphan_data", data_out, 8'hAA);
    chk("orphan_no_trunc", err_trunc, 0);
    cyc(1, 1, 8'h08, 0);
    cyc(1, 0, 8'h51, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    chk("trunc_busy_before", pkt_busy, 1);
    chk("trunc_before", err_trunc, 0);
    cyc(1, 1, 8'h04, 0);
    cyc(0, 0, 8'h00, 1);
    chk("trunc_flag", err_trunc, 1);
    chk("trunc_busy", pkt_busy, 1);
    chk("trunc_rdcnt", dut.rd_cnt, 2);
    idle(3);
    chk("sticky_orphan", err_orphan, 1);
    chk("sticky_trunc", err_trunc, 1);
    flush_cycle(0);
    chk("clr_errs", {err_orphan, err_trunc}, 0);

    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
Parametrised, packet-aware output FIFO for the 1x3 router, one instance per destination port. It stores DATA_W-bit bytes, each tagged with a header flag (lfd_state) captured at write time. On the read side it tracks the packet being drained (header length -> payload + parity), and reports occupancy, almost-full and framing errors to the router FSM/synchroniser.

Parameters:
DATA_W, 8, byte width; header layout is {payload_len[DATA_W-1:2], addr[1:0]}
DEPTH, 16, number of entries; must be a power of 2, >= 4
ADDR_W, 4, log2(DEPTH)
AF_LEVEL, 14, occupancy at or above which almost_full asserts; 1 <= AF_LEVEL <= DEPTH

Ports:
clock  in  1  single clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
soft_reset  in  1  synchronous flush (router time-out), active high
write_enb  in  1  write request
lfd_state  in  1  marks data_in as a header byte
data_in  in  DATA_W  write data
read_enb  in  1  read request
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out carries a newly read byte this cycle
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= AF_LEVEL
count  out  ADDR_W+1  occupancy 0..DEPTH
pkt_busy  out  1  header read, packet not yet fully drained
err_orphan  out  1  sticky: non-header byte read while pkt_busy==0
err_trunc  out  1  sticky: header byte read while pkt_busy==1

Behaviour:
- Storage: DEPTH x (DATA_W+1). Bit DATA_W holds lfd_state at write.
- Pointers: ADDR_W+1 bits each, wrap bit as MSB. empty when pointers are equal. full when the MSBs differ and the low bits are equal. Wrap-around is natural modulo 2^(ADDR_W+1).
- Write accepted iff write_enb && !full. Read accepted iff read_enb && !empty. Flags are sampled before the edge. There is no bypass:
  - full with read and write: read accepted, write dropped, count -1.
  - empty with read and write: write accepted, read ignored, count +1.
- count: +1 on write only, -1 on read only, unchanged when both are accepted. full/empty/almost_full are combinational from count/pointers and update the cycle after the edge.
- Read latency: 1 cycle. On an accepted read at edge N, data_out and data_valid=1 appear after edge N. data_valid=0 on any edge without an accepted read. data_out holds its last value when data_valid=0.
- Packet tracking (read side), with rd_cnt width DATA_W-1:
  - Accepted read of an lfd-tagged entry: rd_cnt <= entry[DATA_W-1:2] + 1 (payload + parity), pkt_busy <= 1. If pkt_busy was already 1, err_trunc <= 1 and rd_cnt is reloaded.
  - Accepted read of a non-lfd entry with pkt_busy==1: rd_cnt <= rd_cnt - 1. When rd_cnt==1, pkt_busy <= 0 on that same edge (parity byte).
  - Accepted read of a non-lfd entry with pkt_busy==0: byte is still output, err_orphan <= 1.
  - Zero-length header (payload_len 0): rd_cnt=1, so only the parity byte follows.
- Priority per edge: resetn=0 > soft_reset=1 > normal operation.
- resetn=0 or soft_reset=1 (flush): pointers=0, count=0, rd_cnt=0, pkt_busy=0, data_out=0, data_valid=0, err_orphan=0, err_trunc=0. Resulting outputs: empty=1, full=0, almost_full=0. Writes and reads presented in a flush cycle are discarded. Memory contents need not be cleared.
- Mid-packet flush: partially drained packet is abandoned. The next byte read must be a header, otherwise err_orphan sets.

Test Plan:
1. resetn low 1 cycle, then soft_reset 1 cycle -> empty=1, full=0, almost_full=0, count=0, data_valid=0, pkt_busy=0, err_*=0.
2. Write header 8'h11 (len 4, addr 01, lfd=1), 4 random payload bytes, parity; wait 2 cycles; read until empty -> count=6 before reads; 6 data_valid pulses, bytes in write order; pkt_busy=1 after header read with rd_cnt=5; pkt_busy=0 after parity read; empty=1; no errors.
3. Write 16 bytes -> almost_full rises at count=14, full at 16; 17th write ignored (count stays 16); read+write in the same cycle while full -> count=15, written byte lost.
4. Write 10/read 10, then write 16 distinct values -> full=1 with pointers wrapped; read 16 -> values returned in order, empty=1.
5. Packet len 4 written, 2 bytes read (pkt_busy=1, count=4); soft_reset with write_enb=1 in the same cycle -> next cycle count=0, empty=1, pkt_busy=0, data_valid=0; the concurrent write is absent.
6. After flush, write non-lfd 8'hAA and read it -> err_orphan=1, data_out=8'hAA. Then write header len 2 and read it plus 1 byte, then write and read another header -> err_trunc=1. Both flags stay set until soft_reset.
